// File: rtl/wb_spi_slave_regs_if.sv
// Wishbone responder bundle for wb_spi_slave_regs.
//
// Handshake: an access is requested while wb_cyc & wb_stb are high. The
// responder performs it in the first such cycle that is not itself an ack
// cycle and raises wb_ack_o for exactly one cycle on the next clock, with
// wb_dat_o valid in that same cycle. The master drops wb_stb on seeing ack.
//
// Signals: wb_cyc, wb_stb, wb_we, wb_adr[7:0], wb_dat_i[7:0] (master -> slave)
//          wb_dat_o[7:0], wb_ack_o                           (slave -> master)
interface wb_spi_slave_regs_if;
   logic       wb_cyc;
   logic       wb_stb;
   logic       wb_we;
   logic [7:0] wb_adr;
   logic [7:0] wb_dat_i;
   logic [7:0] wb_dat_o;
   logic       wb_ack_o;

   modport master (
      output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
      input  wb_dat_o, wb_ack_o
   );

   modport slave (
      input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
      output wb_dat_o, wb_ack_o
   );
endinterface

// File: rtl/wb_spi_slave_regs.sv
// Soft SPI slave (mode 0, MSB first) with an EFB-compatible Wishbone
// register subset. The SPI pins are oversampled on clk_96m.
//
// Ports:
//   clk_96m   system clock
//   wb_rst    synchronous active-high reset
//   wb        Wishbone responder (wb_spi_slave_regs_if.slave)
//   spi_clk   external SPI clock (async)
//   spi_mosi  SPI data in (async)
//   spi_scsn  SPI chip select, active-low (async)
//   spi_miso  SPI data out, MISO_IDLE while deselected
//   spi_irq   registered |(IRQ & IRQEN)
module wb_spi_slave_regs #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] TX_DUMMY    = 8'hFF,
   parameter logic       MISO_IDLE   = 1'b1
) (
   input  logic                       clk_96m,
   input  logic                       wb_rst,
   wb_spi_slave_regs_if.slave         wb,
   input  logic                       spi_clk,
   output logic                       spi_miso,
   input  logic                       spi_mosi,
   input  logic                       spi_scsn,
   output logic                       spi_irq
);

   localparam logic [7:0] ADR_CR2   = 8'h56;
   localparam logic [7:0] ADR_TXDR  = 8'h59;
   localparam logic [7:0] ADR_SR    = 8'h5A;
   localparam logic [7:0] ADR_RXDR  = 8'h5B;
   localparam logic [7:0] ADR_IRQ   = 8'h5C;
   localparam logic [7:0] ADR_IRQEN = 8'h5D;

   logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_csn_sync;
   logic       r_sclk_d, r_csn_d;
   logic       r_ack;
   logic [7:0] r_dat_o;
   logic [7:0] r_cr2, r_txdr, r_rxdr;
   logic       r_trdy, r_rrdy, r_roe;
   logic [3:1] r_irq_flags;   // {RRDY, TRDY, ROE}
   logic [3:1] r_irqen;
   logic [6:0] r_rx_sr;       // bits received so far in this byte
   logic [6:0] r_tx_sr;       // bits still to be driven after the current one
   logic [2:0] r_bit_cnt;
   logic       r_miso, r_irq;

   logic       w_sclk, w_mosi, w_csn, w_sel;
   logic       w_csn_fall, w_rx_edge, w_tx_edge;
   logic       w_byte_done, w_tx_load, w_roe_set;
   logic [7:0] w_rx_byte, w_tx_next, w_rdata;
   logic       w_access, w_wr, w_rd;
   logic       w_rd_sr, w_rd_rxdr;
   logic [3:1] w_irq_clr, w_irq_set;

   assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
   assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
   assign w_csn  = r_csn_sync[SYNC_STAGES-1];
   assign w_sel  = ~w_csn;

   // A select edge takes priority over any clock edge in the same cycle.
   assign w_csn_fall = ~w_csn & r_csn_d;
   assign w_rx_edge  = w_sel & ~w_csn_fall &  w_sclk & ~r_sclk_d;
   assign w_tx_edge  = w_sel & ~w_csn_fall & ~w_sclk &  r_sclk_d;

   assign w_rx_byte   = {r_rx_sr, w_mosi};
   assign w_byte_done = w_rx_edge & (r_bit_cnt == 3'd7);
   assign w_tx_load   = w_csn_fall | w_byte_done;
   // TRDY=0 means a written byte is waiting in TXDR.
   assign w_tx_next   = r_trdy ? TX_DUMMY : r_txdr;

   // The ack cycle never starts a new access.
   assign w_access  = wb.wb_cyc & wb.wb_stb & ~r_ack;
   assign w_wr      = w_access &  wb.wb_we;
   assign w_rd      = w_access & ~wb.wb_we;
   assign w_rd_sr   = w_rd & (wb.wb_adr == ADR_SR);
   assign w_rd_rxdr = w_rd & (wb.wb_adr == ADR_RXDR);

   // A byte landing while RXDR is being read is not an overrun.
   assign w_roe_set = w_byte_done & r_rrdy & ~w_rd_rxdr;
   assign w_irq_set = {w_byte_done, w_tx_load, w_roe_set};
   assign w_irq_clr = (w_wr && wb.wb_adr == ADR_IRQ) ? wb.wb_dat_i[3:1] : 3'b000;

   always_comb begin
      w_rdata = 8'h00;
      case (wb.wb_adr)
         ADR_CR2:   w_rdata = r_cr2;
         ADR_SR:    w_rdata = {3'b000, r_trdy, r_rrdy, 1'b0, r_roe, w_sel};
         ADR_RXDR:  w_rdata = r_rxdr;
         ADR_IRQ:   w_rdata = {4'h0, r_irq_flags, 1'b0};
         ADR_IRQEN: w_rdata = {4'h0, r_irqen, 1'b0};
         default:   w_rdata = 8'h00;
      endcase
   end

   always_ff @(posedge clk_96m) begin
      if (wb_rst) begin
         r_sclk_sync <= '0;
         r_mosi_sync <= '0;
         r_csn_sync  <= '1;
         r_sclk_d    <= 1'b0;
         r_csn_d     <= 1'b1;
         r_ack       <= 1'b0;
         r_dat_o     <= 8'h00;
         r_cr2       <= 8'h00;
         r_txdr      <= 8'h00;
         r_rxdr      <= 8'h00;
         r_trdy      <= 1'b1;
         r_rrdy      <= 1'b0;
         r_roe       <= 1'b0;
         r_irq_flags <= 3'b000;
         r_irqen     <= 3'b000;
         r_rx_sr     <= 7'h00;
         r_tx_sr     <= 7'h00;
         r_bit_cnt   <= 3'd0;
         r_miso      <= MISO_IDLE;
         r_irq       <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clk};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], spi_scsn};
         r_sclk_d    <= w_sclk;
         r_csn_d     <= w_csn;

         r_ack   <= w_access;
         r_dat_o <= w_rd ? w_rdata : 8'h00;

         if (w_wr && wb.wb_adr == ADR_CR2)   r_cr2   <= wb.wb_dat_i;
         if (w_wr && wb.wb_adr == ADR_IRQEN) r_irqen <= wb.wb_dat_i[3:1];

         // A write coinciding with a load is held for the following byte.
         if (w_tx_load) r_trdy <= 1'b1;
         if (w_wr && wb.wb_adr == ADR_TXDR) begin
            r_txdr <= wb.wb_dat_i;
            r_trdy <= 1'b0;
         end

         if (w_csn || w_csn_fall)  r_bit_cnt <= 3'd0;
         else if (w_rx_edge)       r_bit_cnt <= r_bit_cnt + 3'd1;
         if (w_rx_edge)   r_rx_sr <= w_rx_byte[6:0];
         if (w_byte_done) r_rxdr  <= w_rx_byte;

         // Set beats clear for all status flags.
         if (w_rd_rxdr)   r_rrdy <= 1'b0;
         if (w_byte_done) r_rrdy <= 1'b1;
         if (w_rd_sr)     r_roe  <= 1'b0;
         if (w_roe_set)   r_roe  <= 1'b1;
         r_irq_flags <= (r_irq_flags & ~w_irq_clr) | w_irq_set;

         // Bit 7 goes out straight away on a load; the falling edge that
         // follows a byte boundary (counter 0) must not shift it away.
         if (w_csn) begin
            r_miso <= MISO_IDLE;
         end else if (w_tx_load) begin
            r_tx_sr <= w_tx_next[6:0];
            r_miso  <= w_tx_next[7];
         end else if (w_tx_edge && r_bit_cnt != 3'd0) begin
            r_tx_sr <= {r_tx_sr[5:0], 1'b0};
            r_miso  <= r_tx_sr[6];
         end

         r_irq <= |(r_irq_flags & r_irqen);
      end
   end

   assign wb.wb_ack_o = r_ack;
   assign wb.wb_dat_o = r_dat_o;
   assign spi_miso    = r_miso;
   assign spi_irq     = r_irq;

endmodule

// File: tb/tb_wb_spi_slave_regs.sv
// Directed bench for wb_spi_slave_regs: Wishbone register accesses plus a
// mode-0 SPI master model driving the pins with 6-cycle clock phases.
module tb_wb_spi_slave_regs;

   logic clk_96m = 1'b0;
   logic wb_rst;
   logic spi_clk, spi_miso, spi_mosi, spi_scsn, spi_irq;

   wb_spi_slave_regs_if wb_if ();

   wb_spi_slave_regs dut (
      .clk_96m  (clk_96m),
      .wb_rst   (wb_rst),
      .wb       (wb_if.slave),
      .spi_clk  (spi_clk),
      .spi_miso (spi_miso),
      .spi_mosi (spi_mosi),
      .spi_scsn (spi_scsn),
      .spi_irq  (spi_irq)
   );

   always #5 clk_96m = ~clk_96m;

   int   n_cmp = 0;
   int   n_bad = 0;
   logic irq_at_ack;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance n (>=1) clocks, landing 1 time unit after the edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk_96m);
      #1;
   endtask

   task automatic wb_xfer(input logic we, input logic [7:0] adr, input logic [7:0] wdat,
                          output logic [7:0] rdat, output int lat);
      wb_if.wb_cyc   = 1'b1;
      wb_if.wb_stb   = 1'b1;
      wb_if.wb_we    = we;
      wb_if.wb_adr   = adr;
      wb_if.wb_dat_i = wdat;
      lat = 0;
      do begin
         tick(1);
         lat++;
      end while (wb_if.wb_ack_o !== 1'b1 && lat < 8);
      check("ack_seen", {31'd0, wb_if.wb_ack_o}, 32'd1);
      rdat       = wb_if.wb_dat_o;
      irq_at_ack = spi_irq;
      wb_if.wb_cyc = 1'b0;
      wb_if.wb_stb = 1'b0;
      wb_if.wb_we  = 1'b0;
      tick(1);
      check("ack_single", {31'd0, wb_if.wb_ack_o}, 32'd0);
   endtask

   task automatic wb_wr(input logic [7:0] adr, input logic [7:0] dat);
      logic [7:0] d;
      int l;
      wb_xfer(1'b1, adr, dat, d, l);
   endtask

   task automatic wb_rd_chk(input string tag, input logic [7:0] adr, input logic [7:0] exp);
      logic [7:0] d;
      int l;
      wb_xfer(1'b0, adr, 8'h00, d, l);
      check(tag, {24'd0, d}, {24'd0, exp});
   endtask

   task automatic spi_bit(input logic b, output logic m);
      spi_mosi = b;
      tick(6);
      spi_clk = 1'b1;
      m = spi_miso;
      tick(6);
      spi_clk = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      logic m;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(tx[i], m);
         rx[i] = m;
      end
   endtask

   task automatic cs_low();
      spi_scsn = 1'b0;
      tick(6);
   endtask

   task automatic cs_high();
      tick(4);
      spi_scsn = 1'b1;
      tick(6);
   endtask

   initial begin
      logic [7:0] rx, v, d;
      logic m;
      int lat, n;

      wb_rst = 1'b1;
      spi_clk = 1'b0; spi_mosi = 1'b0; spi_scsn = 1'b1;
      wb_if.wb_cyc = 1'b0; wb_if.wb_stb = 1'b0; wb_if.wb_we = 1'b0;
      wb_if.wb_adr = 8'h00; wb_if.wb_dat_i = 8'h00;
      tick(3);
      check("rst_ack",  {31'd0, wb_if.wb_ack_o}, 32'd0);
      check("rst_dat",  {24'd0, wb_if.wb_dat_o}, 32'd0);
      check("rst_irq",  {31'd0, spi_irq}, 32'd0);
      check("rst_miso", {31'd0, spi_miso}, 32'd1);
      wb_rst = 1'b0;
      tick(2);

      // Register access basics
      wb_xfer(1'b1, 8'h56, 8'h00, d, lat);
      check("cr2_wr_lat", lat, 1);
      wb_xfer(1'b1, 8'h5D, 8'h08, d, lat);
      check("irqen_wr_lat", lat, 1);
      wb_rd_chk("irqen_rd", 8'h5D, 8'h08);
      wb_rd_chk("sr_idle", 8'h5A, 8'h10);
      wb_wr(8'h56, 8'h3A);
      wb_rd_chk("cr2_rd", 8'h56, 8'h3A);
      wb_wr(8'h40, 8'h77);
      wb_rd_chk("unmapped_rd", 8'h40, 8'h00);

      // Receive 0xA5 with RRDY interrupt enabled
      v = 8'hA5;
      cs_low();
      for (int i = 7; i >= 1; i--) begin
         spi_bit(v[i], m);
         rx[i] = m;
      end
      spi_mosi = v[0];
      tick(6);
      check("irq_before_8th", {31'd0, spi_irq}, 32'd0);
      spi_clk = 1'b1;
      rx[0] = spi_miso;
      n = 0;
      while (spi_irq !== 1'b1 && n < 10) begin
         tick(1);
         n++;
      end
      check("irq_rise_in_6", {31'd0, (n <= 6 && spi_irq === 1'b1)}, 32'd1);
      if (n < 6) tick(6 - n);
      spi_clk = 1'b0;
      check("miso_dummy_a5", {24'd0, rx}, 32'hFF);
      wb_rd_chk("sr_after_a5", 8'h5A, 8'h19);
      wb_rd_chk("rxdr_a5", 8'h5B, 8'hA5);
      wb_rd_chk("sr_rrdy_clr", 8'h5A, 8'h11);
      check("irq_sticky", {31'd0, spi_irq}, 32'd1);
      wb_wr(8'h5C, 8'h08);
      check("irq_at_clr_ack", {31'd0, irq_at_ack}, 32'd1);
      check("irq_dropped", {31'd0, spi_irq}, 32'd0);
      wb_rd_chk("irq_flags_trdy", 8'h5C, 8'h04);
      cs_high();

      // Transmit from TXDR, then dummy
      wb_wr(8'h59, 8'h3C);
      wb_rd_chk("txdr_wo", 8'h59, 8'h00);
      wb_rd_chk("sr_trdy_clr", 8'h5A, 8'h00);
      cs_low();
      spi_byte(8'h00, rx);
      check("miso_3c", {24'd0, rx}, 32'h3C);
      wb_rd_chk("sr_after_tx", 8'h5A, 8'h19);
      wb_rd_chk("rxdr_00", 8'h5B, 8'h00);
      spi_byte(8'h00, rx);
      check("miso_ff_2nd", {24'd0, rx}, 32'hFF);
      wb_rd_chk("irq_flags_tx", 8'h5C, 8'h0C);
      cs_high();
      wb_rd_chk("rxdr_00b", 8'h5B, 8'h00);
      wb_wr(8'h5C, 8'h0E);
      wb_rd_chk("irq_cleared", 8'h5C, 8'h00);

      // Overrun
      cs_low();
      spi_byte(8'h11, rx);
      spi_byte(8'h22, rx);
      cs_high();
      wb_rd_chk("sr_roe", 8'h5A, 8'h1A);
      wb_rd_chk("irq_roe", 8'h5C, 8'h0E);
      wb_rd_chk("rxdr_22", 8'h5B, 8'h22);
      wb_rd_chk("sr_roe_clr", 8'h5A, 8'h10);
      wb_wr(8'h5C, 8'h0E);

      // Partial byte discarded on deselect
      v = 8'hF0;
      cs_low();
      for (int i = 7; i >= 3; i--) spi_bit(v[i], m);
      cs_high();
      wb_rd_chk("sr_partial", 8'h5A, 8'h10);
      wb_rd_chk("irq_partial", 8'h5C, 8'h04);
      cs_low();
      spi_byte(8'h81, rx);
      cs_high();
      wb_rd_chk("sr_81", 8'h5A, 8'h18);
      wb_rd_chk("rxdr_81", 8'h5B, 8'h81);
      wb_wr(8'h5C, 8'h0E);

      // Reset mid-transfer
      wb_wr(8'h5D, 8'h0E);
      wb_wr(8'h56, 8'h3A);
      v = 8'hC3;
      cs_low();
      for (int i = 7; i >= 4; i--) spi_bit(v[i], m);
      check("irq_pre_rst", {31'd0, spi_irq}, 32'd1);
      wb_rst = 1'b1;
      tick(1);
      check("mid_rst_ack",  {31'd0, wb_if.wb_ack_o}, 32'd0);
      check("mid_rst_dat",  {24'd0, wb_if.wb_dat_o}, 32'd0);
      check("mid_rst_irq",  {31'd0, spi_irq}, 32'd0);
      check("mid_rst_miso", {31'd0, spi_miso}, 32'd1);
      wb_rst = 1'b0;
      spi_scsn = 1'b1;
      tick(6);
      wb_rd_chk("rst_irqen", 8'h5D, 8'h00);
      wb_rd_chk("rst_cr2", 8'h56, 8'h00);
      wb_rd_chk("rst_sr", 8'h5A, 8'h10);
      wb_rd_chk("rst_irq_flags", 8'h5C, 8'h00);
      cs_low();
      spi_byte(8'h5A, rx);
      cs_high();
      wb_rd_chk("rxdr_5a", 8'h5B, 8'h5A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
